// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin resource arbiter.
// Optional feature macro: RR_ARB_TIMEOUT_EN (hold timeout / revocation).
package rr_arb_pkg;

    // Largest supported number of requesters.
    localparam int RR_ARB_MAX_N = 16;

    // Arbiter FSM states. OWNED means the shared resource is ON.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWNED    = 2'd1,
        COOLDOWN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: finds the first set request at or above ptr_i,
// wrapping from N-1 back to 0. Purely combinational.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [N-1:0]     onehot_o
);

    // Scan from ptr_i upward; the first request seen is the winner.
    always_comb begin
        int j;
        j        = 0;
        valid_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_o && req_i[j]) begin
                valid_o     = 1'b1;
                idx_o       = IDX_W'(j);
                onehot_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter sharing one ON/OFF resource among N requesters.
// busy_o drives the resource enable. Ownership ends on rel from the owner,
// or, when RR_ARB_TIMEOUT_EN is defined, on hold timeout (HOLD_MAX+1 cycles).
// Handshake: req_i is a level held until grant_o shows that agent; rel_i is a
// one-cycle pulse and only the bit of the current owner is acted on.
module rr_resource_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 15,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             areset_n_i,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     rel_i,
    output logic [N-1:0]     grant_o,
    output logic             busy_o,
    output logic [IDX_W-1:0] owner_o,
    output logic             timeout_o,
    output arb_state_t       dbg_state_o,
    output logic [IDX_W-1:0] dbg_ptr_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [N-1:0]     pick_onehot;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    rr_pick #(
        .N (N)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    // State, pointer and registered outputs.
    always_ff @(posedge clk_i or negedge areset_n_i) begin
        if (!areset_n_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Hold counter for the current owner.
    always_ff @(posedge clk_i or negedge areset_n_i) begin
        if (!areset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next-state logic: grant from IDLE, release/timeout from OWNED, one OFF cycle in COOLDOWN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWNED;
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    ptr_d   = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            OWNED: begin
                // A release always wins over a coincident timeout.
                if (rel_i[owner_q]) begin
                    state_d = COOLDOWN;
                    grant_d = '0;
                    owner_d = '0;
                    busy_d  = 1'b0;
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (cnt_q == HOLD_MAX_C) begin
                    state_d   = COOLDOWN;
                    grant_d   = '0;
                    owner_d   = '0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            COOLDOWN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign owner_o     = owner_q;
    assign timeout_o   = timeout_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Bench for rr_resource_arbiter (N=4, HOLD_MAX=3): directed steps from the
// test plan followed by random traffic, all compared against a reference
// model of ownership (owner index, forced-off gap, hold count, pointer).
module tb_rr_resource_arbiter;
    import rr_arb_pkg::*;

    localparam int N        = 4;
    localparam int HOLD_MAX = 3;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic             clk;
    logic             areset_n;
    logic [N-1:0]     req;
    logic [N-1:0]     rel;
    logic [N-1:0]     grant;
    logic             busy;
    logic [1:0]       owner;
    logic             timeout;
    arb_state_t       dbg_state;
    logic [1:0]       dbg_ptr;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];

    // Reference model
    int m_owner;   // -1 when nobody owns
    int m_gap;     // forced OFF cycles still pending
    int m_ptr;
    int m_held;
    bit m_to;

    rr_resource_arbiter #(
        .N        (N),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk_i       (clk),
        .areset_n_i  (areset_n),
        .req_i       (req),
        .rel_i       (rel),
        .grant_o     (grant),
        .busy_o      (busy),
        .owner_o     (owner),
        .timeout_o   (timeout),
        .dbg_state_o (dbg_state),
        .dbg_ptr_o   (dbg_ptr)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_gap   = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l);
        int  c;
        bit  found;
        m_to  = 1'b0;
        found = 1'b0;
        if (m_owner >= 0) begin
            if (l[m_owner]) begin
                m_owner = -1;
                m_gap   = 1;
            end else if (TIMEOUT_ON && m_held == HOLD_MAX) begin
                m_owner = -1;
                m_gap   = 1;
                m_to    = 1'b1;
            end else if (m_held < HOLD_MAX) begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && r[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_ptr   = (c + 1) % N;
                    m_held  = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] eg, es;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        es = (m_owner >= 0) ? 32'(OWNED) : ((m_gap > 0) ? 32'(COOLDOWN) : 32'(IDLE));
        chk({tag, ".grant"},   32'(grant),     eg);
        chk({tag, ".busy"},    32'(busy),      32'(m_owner >= 0));
        chk({tag, ".owner"},   32'(owner),     (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk({tag, ".timeout"}, 32'(timeout),   32'(m_to));
        chk({tag, ".ptr"},     32'(dbg_ptr),   32'(m_ptr));
        chk({tag, ".state"},   32'(dbg_state), es);
    endtask

    // One clock: inputs stay stable across the edge, outputs checked 1 ns later.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (areset_n) model_step(req, rel);
        #1;
        check_all(tag);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        areset_n = 1'b0;
        req      = '0;
        rel      = '0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        areset_n = 1'b1;
    endtask

    initial begin
        int n;
        int w;
        areset_n = 1'b0;
        req      = '0;
        rel      = '0;
        model_reset();
        #1;
        check_all("por");
        chk("por.grant", 32'(grant), 32'd0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;

        // First grant from ptr=0
        req = 4'b0110;
        cycle("t1");
        chk("t1.grant", 32'(grant), 32'h2);
        chk("t1.owner", 32'(owner), 32'd1);
        chk("t1.ptr",   32'(dbg_ptr), 32'd2);

        // Release by owner 1 while req[2] held: two OFF cycles then agent 2
        req = 4'b0100;
        rel = 4'b0010;
        cycle("t2a");
        chk("t2.off1", 32'(grant), 32'd0);
        rel = 4'b0000;
        cycle("t2b");
        chk("t2.off2", 32'(grant), 32'd0);
        cycle("t2c");
        chk("t2.grant", 32'(grant), 32'h4);
        chk("t2.ptr",   32'(dbg_ptr), 32'd3);
        rel = 4'b0100;
        req = 4'b0000;
        cycle("t2d");
        rel = 4'b0000;

        // Full contention: order 0,1,2,3,0 from a fresh pointer
        apply_reset();
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (grant == '0 && w < 8) begin
                cycle("t3w");
                w++;
            end
            chk("t3.wait_bound", 32'(w < 8), 32'd1);
            chk("t3.order", 32'(owner), 32'(exp_q.pop_front()));
            rel = grant;
            cycle("t3r");
            rel = '0;
        end
        req = '0;

        // Owner 0 never releases
        apply_reset();
        req = 4'b0001;
        cycle("t4g");
        req = 4'b0000;
        if (TIMEOUT_ON) begin
            n = 0;
            while (grant != '0 && n < 200) begin
                n++;
                cycle("t4h");
            end
            chk("t4.hold_cycles", 32'(n), 32'(HOLD_MAX + 1));
            chk("t4.timeout_pulse", 32'(timeout), 32'd1);
            cycle("t4c");
            chk("t4.timeout_clear", 32'(timeout), 32'd0);
            chk("t4.grant_off", 32'(grant), 32'd0);
        end else begin
            for (int k = 0; k < 100; k++) begin
                cycle("t4h");
                chk("t4.held", 32'(grant), 32'h1);
                chk("t4.no_timeout", 32'(timeout), 32'd0);
            end
            rel = 4'b0001;
            cycle("t4r");
            rel = '0;
            chk("t4.released", 32'(grant), 32'd0);
        end

        // Release on the last hold cycle, non-owner release ignored
        apply_reset();
        req = 4'b0001;
        cycle("t5g");
        req = 4'b0000;
        rel = 4'b0100;
        cycle("t5n");
        chk("t5.nonowner_rel", 32'(grant), 32'h1);
        rel = 4'b0000;
        cycle("t5h2");
        cycle("t5h3");
        chk("t5.still_owned", 32'(grant), 32'h1);
        rel = 4'b0001;
        cycle("t5r");
        rel = 4'b0000;
        chk("t5.rel_grant", 32'(grant), 32'd0);
        chk("t5.rel_no_timeout", 32'(timeout), 32'd0);
        chk("t5.cooldown", 32'(dbg_state), 32'(COOLDOWN));
        cycle("t5i");

        // Asynchronous reset while owned
        req = 4'b0010;
        cycle("t6g");
        req = 4'b0000;
        chk("t6.owned", 32'(grant), 32'h2);
        areset_n = 1'b0;
        model_reset();
        #1;
        chk("t6.async_grant", 32'(grant), 32'd0);
        chk("t6.async_busy",  32'(busy),  32'd0);
        chk("t6.async_timeout", 32'(timeout), 32'd0);
        @(posedge clk);
        #1;
        areset_n = 1'b1;
        req = 4'b1000;
        cycle("t6n");
        chk("t6.grant3", 32'(grant), 32'h8);
        chk("t6.ptr_wrap", 32'(dbg_ptr), 32'd0);
        req = 4'b0000;

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            req = 4'($urandom_range(0, 15));
            rel = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            cycle("rnd");
        end
        req = '0;
        rel = '0;
        cycle("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
